// File: rtl/ym3438_slot_acc.sv
// Slot-serial accumulator ring: SLOTS words circulate through a two-phase
// master/slave shift chain; the head word is cleared, loaded or stepped each slot.
module ym3438_slot_acc #(
    parameter int DATA_WIDTH = 10,
    parameter int SLOTS      = 24,
    parameter int STEP_WIDTH = 4,
    parameter int SATURATE   = 0
) (
    input  logic                     MCLK,
    input  logic                     reset_n,
    input  logic                     c1,
    input  logic                     c2,
    input  logic                     clr,
    input  logic                     load,
    input  logic [DATA_WIDTH-1:0]    load_val,
    input  logic [STEP_WIDTH-1:0]    step,
    output logic [DATA_WIDTH-1:0]    val,
    output logic                     c_out,
    output logic [$clog2(SLOTS)-1:0] slot,
    output logic                     sync
);

    localparam int SW = $clog2(SLOTS);
    localparam logic [SW-1:0] LAST_SLOT = SW'(SLOTS - 1);

    logic [DATA_WIDTH-1:0] r_m [SLOTS];
    logic [DATA_WIDTH-1:0] r_s [SLOTS];
    logic [SW-1:0]         r_slot;

    logic [DATA_WIDTH-1:0] w_head;
    logic [DATA_WIDTH-1:0] w_base;
    logic [DATA_WIDTH:0]   w_step_ext;
    logic [DATA_WIDTH:0]   w_sum;
    logic [DATA_WIDTH-1:0] w_nxt;
    logic                  w_cout;

    assign w_head     = r_s[SLOTS-1];
    assign w_base     = load ? load_val : w_head;
    assign w_step_ext = {{(DATA_WIDTH + 1 - STEP_WIDTH){1'b0}}, step};
    assign w_sum      = {1'b0, w_base} + w_step_ext;

    // clr wins over load and step; saturation clamps instead of wrapping
    always_comb begin
        w_nxt  = w_sum[DATA_WIDTH-1:0];
        w_cout = w_sum[DATA_WIDTH];
        if (clr) begin
            w_nxt  = '0;
            w_cout = 1'b0;
        end else if (SATURATE != 0) begin
            if (w_sum[DATA_WIDTH]) begin
                w_nxt  = '1;
                w_cout = 1'b1;
            end
        end
    end

    // c1 and c2 on one edge both read pre-edge state, so s takes the old m
    always_ff @(posedge MCLK) begin
        if (!reset_n) begin
            for (int k = 0; k < SLOTS; k++) begin
                r_m[k] <= '0;
                r_s[k] <= '0;
            end
            r_slot <= '0;
        end else begin
            if (c1) begin
                r_m[0] <= w_nxt;
                for (int k = 1; k < SLOTS; k++) begin
                    r_m[k] <= r_s[k-1];
                end
            end
            if (c2) begin
                for (int k = 0; k < SLOTS; k++) begin
                    r_s[k] <= r_m[k];
                end
                r_slot <= (r_slot == LAST_SLOT) ? '0 : r_slot + 1'b1;
            end
        end
    end

    assign val   = w_head;
    assign c_out = w_cout;
    assign slot  = r_slot;
    assign sync  = (r_slot == LAST_SLOT);

endmodule

// File: tb/tb_ym3438_slot_acc.sv
// Bench for ym3438_slot_acc: wrap and saturate instances share stimulus and are
// checked every cycle against a slot-indexed memory model plus literal expectations.
module tb_ym3438_slot_acc;

    localparam int DW    = 10;
    localparam int SLOTS = 24;
    localparam int SW    = 5;
    localparam int STW   = 4;
    localparam int MAXV  = (1 << DW) - 1;

    logic MCLK = 1'b0;
    always #5 MCLK = ~MCLK;

    logic           reset_n;
    logic           c1, c2, clr, load;
    logic [DW-1:0]  load_val;
    logic [STW-1:0] step;

    logic [DW-1:0]  val0, val1;
    logic           c_out0, c_out1;
    logic [SW-1:0]  slot0, slot1;
    logic           sync0, sync1;

    ym3438_slot_acc #(.DATA_WIDTH(DW), .SLOTS(SLOTS), .STEP_WIDTH(STW), .SATURATE(0)) u_dut_wrap (
        .MCLK(MCLK), .reset_n(reset_n), .c1(c1), .c2(c2), .clr(clr), .load(load),
        .load_val(load_val), .step(step), .val(val0), .c_out(c_out0), .slot(slot0), .sync(sync0)
    );

    ym3438_slot_acc #(.DATA_WIDTH(DW), .SLOTS(SLOTS), .STEP_WIDTH(STW), .SATURATE(1)) u_dut_sat (
        .MCLK(MCLK), .reset_n(reset_n), .c1(c1), .c2(c2), .clr(clr), .load(load),
        .load_val(load_val), .step(step), .val(val1), .c_out(c_out1), .slot(slot1), .sync(sync1)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // model: one word per slot number, plus the value computed at c1 awaiting c2
    int mem [2][SLOTS];
    int pend [2];
    int m_cur = 0;
    bit chk_en = 1'b0;

    // returns {carry, next} as carry*2^DW + next
    function automatic int model_nxt(input int sat, input int head, input int c,
                                     input int ld, input int lv, input int st);
        int base, sum;
        base = ld ? lv : head;
        sum  = base + st;
        if (c != 0) return 0;
        if (sum > MAXV) return sat ? ((1 << DW) | MAXV) : ((1 << DW) | (sum - (1 << DW)));
        return sum;
    endfunction

    always @(posedge MCLK) begin
        if (!reset_n) begin
            for (int k = 0; k < 2; k++) begin
                for (int j = 0; j < SLOTS; j++) mem[k][j] <= 0;
                pend[k] <= 0;
            end
            m_cur <= 0;
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (c1) pend[k] <= model_nxt(k, mem[k][m_cur], clr, load, load_val, step) & MAXV;
                if (c2) mem[k][m_cur] <= pend[k];
            end
            if (c2) m_cur <= (m_cur + 1) % SLOTS;
        end
    end

    task automatic check(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    always @(negedge MCLK) begin
        if (chk_en) begin
            check("cyc_val_wrap", val0, mem[0][m_cur]);
            check("cyc_val_sat",  val1, mem[1][m_cur]);
            check("cyc_slot_wrap", slot0, m_cur);
            check("cyc_slot_sat",  slot1, m_cur);
            check("cyc_sync_wrap", sync0, (m_cur == SLOTS - 1) ? 1 : 0);
            check("cyc_sync_sat",  sync1, (m_cur == SLOTS - 1) ? 1 : 0);
            check("cyc_cout_wrap", c_out0,
                  model_nxt(0, mem[0][m_cur], clr, load, load_val, step) >> DW);
            check("cyc_cout_sat", c_out1,
                  model_nxt(1, mem[1][m_cur], clr, load, load_val, step) >> DW);
        end
    end

    task automatic set_in(input int c, input int ld, input int lv, input int st);
        clr      = c[0];
        load     = ld[0];
        load_val = lv[DW-1:0];
        step     = st[STW-1:0];
        #1;
    endtask

    task automatic pulse(input bit a, input bit b);
        c1 = a;
        c2 = b;
        @(posedge MCLK);
        #1;
        c1 = 1'b0;
        c2 = 1'b0;
    endtask

    task automatic cycle();
        pulse(1'b1, 1'b0);
        pulse(1'b0, 1'b1);
    endtask

    task automatic idle_to(input int target);
        set_in(0, 0, 0, 0);
        for (int i = 0; i < SLOTS && m_cur != target; i++) cycle();
        check("slot_at_target", slot0, target);
    endtask

    initial begin
        int syncs, nz, s0;
        reset_n = 1'b0;
        c1 = 1'b0;
        c2 = 1'b0;
        set_in(0, 0, 0, 0);
        repeat (3) @(posedge MCLK);
        #1;
        chk_en = 1'b1;
        check("rst_val",  val0, 0);
        check("rst_slot", slot0, 0);
        check("rst_sync", sync0, 0);
        check("rst_cout", c_out0, 0);
        check("rst_val_sat", val1, 0);
        reset_n = 1'b1;

        // T1: idle revolutions
        syncs = 0;
        for (int i = 0; i < 48; i++) begin
            if (sync0) syncs++;
            cycle();
        end
        check("t1_sync_count", syncs, 2);
        check("t1_slot_wrap", slot0, 0);

        // T2: load slot 5
        idle_to(5);
        set_in(0, 1, 'h155, 0);
        cycle();
        set_in(0, 0, 0, 0);
        check("t2_slot6_zero", val0, 0);
        idle_to(5);
        check("t2_val_slot5", val0, 'h155);
        check("t2_val_slot5_sat", val1, 'h155);

        // T3: overflow at slot 3
        idle_to(3);
        set_in(0, 1, 'h3FF, 0);
        cycle();
        idle_to(3);
        check("t3_loaded_wrap", val0, 'h3FF);
        check("t3_loaded_sat", val1, 'h3FF);
        set_in(0, 0, 0, 1);
        check("t3_cout_wrap", c_out0, 1);
        check("t3_cout_sat", c_out1, 1);
        cycle();
        idle_to(3);
        check("t3_wrapped", val0, 'h000);
        check("t3_saturated", val1, 'h3FF);

        // T4: repeated c1 without c2 versus single c1
        idle_to(10);
        for (int i = 1; i <= 5; i++) begin
            set_in(0, 1, 'h020, i);
            pulse(1'b1, 1'b0);
        end
        check("t4_slot_hold", slot0, 10);
        check("t4_val_hold", val0, 0);
        pulse(1'b0, 1'b1);
        check("t4_slot_once", slot0, 11);
        set_in(0, 1, 'h020, 5);
        cycle();
        idle_to(10);
        check("t4_multi_c1", val0, 'h025);
        cycle();
        check("t4_single_c1", val0, 'h025);

        // T5: fill every slot, then reset with c1=c2=1
        s0 = m_cur;
        for (int i = 0; i < SLOTS; i++) begin
            set_in(0, 1, m_cur * 37 + 1, 0);
            cycle();
        end
        set_in(0, 0, 0, 0);
        check("t5_filled", val0, s0 * 37 + 1);
        reset_n = 1'b0;
        pulse(1'b1, 1'b1);
        reset_n = 1'b1;
        check("t5_rst_val", val0, 0);
        check("t5_rst_slot", slot0, 0);
        check("t5_rst_sync", sync0, 0);
        check("t5_rst_val_sat", val1, 0);
        nz = 0;
        for (int i = 0; i < SLOTS; i++) begin
            if (val0 != 0 || val1 != 0) nz++;
            cycle();
        end
        check("t5_all_zero", nz, 0);

        // T6: clr beats load and step
        idle_to(7);
        set_in(1, 1, 'h0AA, 2);
        check("t6_cout_wrap", c_out0, 0);
        check("t6_cout_sat", c_out1, 0);
        cycle();
        set_in(1, 1, 'h3FF, 2);
        check("t6_cout_carry_masked", c_out0, 0);
        check("t6_cout_carry_masked_sat", c_out1, 0);
        idle_to(7);
        check("t6_cleared", val0, 0);
        check("t6_cleared_sat", val1, 0);

        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
